// File: rtl/instr_encoder_loader_pkg.sv
// Shared instruction-set definitions for the encoder/loader and the control decoder.
// Class enum, major opcodes, unary select codes, error codes and loader states.
package instr_encoder_loader_pkg;

    typedef enum logic [3:0] {
        OP_LDR   = 4'd0,
        OP_STR   = 4'd1,
        OP_ALU   = 4'd2,
        OP_UNARY = 4'd3,
        OP_JMP   = 4'd4,
        OP_BRC   = 4'd5,
        OP_BLT   = 4'd6,
        OP_BEQ   = 4'd7,
        OP_MOV   = 4'd8,
        OP_SHL   = 4'd9,
        OP_ADDI  = 4'd10,
        OP_SUBI  = 4'd11
    } op_class_t;

    localparam logic [2:0] OPC_LS  = 3'b000;
    localparam logic [2:0] OPC_MOV = 3'b001;
    localparam logic [2:0] OPC_ALU = 3'b010;
    localparam logic [2:0] OPC_SHL = 3'b011;
    localparam logic [2:0] OPC_BR  = 3'b100;
    localparam logic [2:0] OPC_BLT = 3'b101;
    localparam logic [2:0] OPC_BEQ = 3'b110;
    localparam logic [2:0] OPC_ARI = 3'b111;

    localparam logic [1:0] SEL_FN0 = 2'b00;
    localparam logic [1:0] SEL_FN1 = 2'b10;
    localparam logic [1:0] SEL_FN2 = 2'b01;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_UNKNOWN  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } load_state_t;

    // Unary sub-op select is not the raw fn value: fn 01 and 10 swap.
    function automatic logic [1:0] unary_sel(input logic [1:0] fn);
        case (fn)
            2'b00:   return SEL_FN0;
            2'b01:   return SEL_FN1;
            2'b10:   return SEL_FN2;
            default: return SEL_FN0;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input stream and instruction-memory write port of the loader.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [1:0]        in_fn;
    logic [2:0]        in_ra;
    logic [2:0]        in_rb;
    logic [4:0]        in_imm;
    logic              in_last;
    logic              im_wen;
    logic [ADDR_W-1:0] im_addr;
    logic [8:0]        im_wdata;

    modport slave (
        input  in_valid, in_op, in_fn, in_ra, in_rb, in_imm, in_last,
        output in_ready, im_wen, im_addr, im_wdata
    );

    modport master (
        output in_valid, in_op, in_fn, in_ra, in_rb, in_imm, in_last,
        input  in_ready, im_wen, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_encoder_loader_encode.sv
// Combinational packer: instruction fields -> 9-bit machine code plus legality flags.
module instr_encode
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic [1:0] i_fn,
    input  logic [2:0] i_ra,
    input  logic [2:0] i_rb,
    input  logic [4:0] i_imm,
    output logic [8:0] o_code,
    output logic       o_legal,
    output logic       o_known
);
    logic w_ra_wide;
    logic w_rb_wide;
    logic w_imm_wide;
    logic w_fn_bad;

    // Field too large for a 2-bit register slot or a 3-bit immediate slot.
    assign w_ra_wide  = i_ra[2];
    assign w_rb_wide  = i_rb[2];
    assign w_imm_wide = |i_imm[4:3];
    assign w_fn_bad   = (i_fn == 2'b11);

    always_comb begin
        o_code  = '0;
        o_legal = 1'b1;
        o_known = 1'b1;
        case (i_op)
            OP_LDR: begin
                o_code  = {OPC_LS, 1'b0, i_ra, i_rb[1:0]};
                o_legal = !w_rb_wide;
            end
            OP_STR: begin
                o_code  = {OPC_LS, 1'b1, i_ra[1:0], i_rb};
                o_legal = !w_ra_wide;
            end
            OP_ALU: begin
                o_code  = {OPC_ALU, i_fn, i_ra[1:0], i_rb[1:0]};
                o_legal = !w_ra_wide && !w_rb_wide && !w_fn_bad;
            end
            OP_UNARY: begin
                o_code  = {OPC_ALU, 2'b11, unary_sel(i_fn), i_ra[1:0]};
                o_legal = !w_ra_wide && !w_fn_bad;
            end
            OP_JMP:  o_code = {OPC_BR, 1'b1, i_imm};
            OP_BRC:  o_code = {OPC_BR, 1'b0, i_imm};
            OP_BLT:  o_code = {OPC_BLT, i_ra, i_rb};
            OP_BEQ:  o_code = {OPC_BEQ, i_ra, i_rb};
            OP_MOV:  o_code = {OPC_MOV, i_ra, i_rb};
            OP_SHL: begin
                o_code  = {OPC_SHL, i_ra, i_imm[2:0]};
                o_legal = !w_imm_wide;
            end
            OP_ADDI: begin
                o_code  = {OPC_ARI, 1'b0, i_ra[1:0], i_imm[2:0]};
                o_legal = !w_ra_wide && !w_imm_wide;
            end
            OP_SUBI: begin
                o_code  = {OPC_ARI, 1'b1, i_ra[1:0], i_imm[2:0]};
                o_legal = !w_ra_wide && !w_imm_wide;
            end
            default: begin
                o_legal = 1'b0;
                o_known = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Loads an encoded program into instruction memory from a field-bundle stream,
// writing sequential addresses from a latched base and flagging encoding errors.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_W-1:0]     o_count,
    output logic                  o_done,
    output logic                  o_err,
    output logic [1:0]            o_err_code
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    load_state_t       r_state;
    load_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic [1:0]        r_err_code;
    logic [1:0]        w_err_code_nxt;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_wdata;
    logic              w_accept;
    logic              w_write;
    logic              w_latch;
    logic [8:0]        w_code;
    logic              w_legal;
    logic              w_known;

    instr_encode u_encode (
        .i_op    (bus.in_op),
        .i_fn    (bus.in_fn),
        .i_ra    (bus.in_ra),
        .i_rb    (bus.in_rb),
        .i_imm   (bus.in_imm),
        .o_code  (w_code),
        .o_legal (w_legal),
        .o_known (w_known)
    );

    assign bus.in_ready = (r_state == S_LOAD);
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The overflowing word is still written; the error takes effect after it.
    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = r_err_code;
        w_write        = 1'b0;
        w_latch        = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    if (!w_known) begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = ERR_UNKNOWN;
                    end else if (!w_legal) begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = ERR_ILLEGAL;
                    end else begin
                        w_write = 1'b1;
                        if (bus.in_last) begin
                            w_state_nxt = S_DONE;
                        end else if (r_count == LAST_IDX) begin
                            w_state_nxt    = S_ERR;
                            w_err_code_nxt = ERR_OVERFLOW;
                        end
                    end
                end
            end
            default: begin
                if (i_start) begin
                    w_state_nxt    = S_LOAD;
                    w_err_code_nxt = ERR_NONE;
                    w_latch        = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base     <= '0;
            r_count    <= '0;
            r_err_code <= '0;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_wen      <= w_write;
            r_err_code <= w_err_code_nxt;
            if (w_latch) begin
                r_base  <= i_base_addr;
                r_count <= '0;
            end
            if (w_write) begin
                r_addr  <= r_base + r_count;
                r_wdata <= w_code;
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign bus.im_wen   = r_wen;
    assign bus.im_addr  = r_addr;
    assign bus.im_wdata = r_wdata;
    assign o_count      = r_count;
    assign o_done       = (r_state == S_DONE);
    assign o_err        = (r_state == S_ERR);
    assign o_err_code   = r_err_code;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomised and directed bench for instr_encoder_loader: a default build and a
// DEPTH=4 build share one stimulus stream and are each compared to a reference model.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    localparam int unsigned AW = 10;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          s_start = 1'b0;
    logic [AW-1:0] s_base = '0;
    logic          s_valid = 1'b0;
    logic [3:0]    s_op = '0;
    logic [1:0]    s_fn = '0;
    logic [2:0]    s_ra = '0;
    logic [2:0]    s_rb = '0;
    logic [4:0]    s_imm = '0;
    logic          s_last = 1'b0;

    instr_encoder_loader_if #(.ADDR_W(AW)) bus_a ();
    instr_encoder_loader_if #(.ADDR_W(AW)) bus_b ();

    assign bus_a.in_valid = s_valid;
    assign bus_a.in_op    = s_op;
    assign bus_a.in_fn    = s_fn;
    assign bus_a.in_ra    = s_ra;
    assign bus_a.in_rb    = s_rb;
    assign bus_a.in_imm   = s_imm;
    assign bus_a.in_last  = s_last;
    assign bus_b.in_valid = s_valid;
    assign bus_b.in_op    = s_op;
    assign bus_b.in_fn    = s_fn;
    assign bus_b.in_ra    = s_ra;
    assign bus_b.in_rb    = s_rb;
    assign bus_b.in_imm   = s_imm;
    assign bus_b.in_last  = s_last;

    logic [AW-1:0] count_a, count_b;
    logic          done_a, done_b, err_a, err_b;
    logic [1:0]    ec_a, ec_b;

    instr_encoder_loader #(.ADDR_W(AW), .DEPTH(1024)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_base_addr(s_base),
        .bus(bus_a), .o_count(count_a), .o_done(done_a), .o_err(err_a), .o_err_code(ec_a)
    );

    instr_encoder_loader #(.ADDR_W(AW), .DEPTH(4)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_base_addr(s_base),
        .bus(bus_b), .o_count(count_b), .o_done(done_b), .o_err(err_b), .o_err_code(ec_b)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    int depth_of [2] = '{1024, 4};
    int m_state  [2];
    int m_cnt    [2];
    int m_base   [2];
    int m_ec     [2];
    int m_wen    [2];
    int m_addr   [2];
    int m_data   [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // kind: 0 encodable, 1 illegal field, 3 unknown class
    function automatic void ref_encode(input int op, input int fn, input int ra, input int rb,
                                       input int imm, output int code, output int kind);
        int sel;
        code = 0;
        kind = 0;
        sel  = (fn == 0) ? 0 : (fn == 1) ? 2 : 1;
        case (op)
            int'(OP_LDR):   begin code = ra * 4 + rb % 4;                 if (rb > 3) kind = 1; end
            int'(OP_STR):   begin code = 32 + (ra % 4) * 8 + rb;          if (ra > 3) kind = 1; end
            int'(OP_ALU):   begin
                code = 128 + fn * 16 + (ra % 4) * 4 + rb % 4;
                if (ra > 3 || rb > 3 || fn == 3) kind = 1;
            end
            int'(OP_UNARY): begin
                code = 128 + 48 + sel * 4 + ra % 4;
                if (ra > 3 || fn == 3) kind = 1;
            end
            int'(OP_JMP):   code = 256 + 32 + imm;
            int'(OP_BRC):   code = 256 + imm;
            int'(OP_BLT):   code = 320 + ra * 8 + rb;
            int'(OP_BEQ):   code = 384 + ra * 8 + rb;
            int'(OP_MOV):   code = 64 + ra * 8 + rb;
            int'(OP_SHL):   begin code = 192 + ra * 8 + imm % 8;          if (imm > 7) kind = 1; end
            int'(OP_ADDI):  begin
                code = 448 + (ra % 4) * 8 + imm % 8;
                if (ra > 3 || imm > 7) kind = 1;
            end
            int'(OP_SUBI):  begin
                code = 448 + 32 + (ra % 4) * 8 + imm % 8;
                if (ra > 3 || imm > 7) kind = 1;
            end
            default:        kind = 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = M_IDLE;
            m_cnt[i]   = 0;
            m_base[i]  = 0;
            m_ec[i]    = 0;
            m_wen[i]   = 0;
            m_addr[i]  = 0;
            m_data[i]  = 0;
        end
    endtask

    task automatic model_step(input int i);
        int code, kind, old;
        m_wen[i] = 0;
        if (m_state[i] == M_LOAD) begin
            if (s_valid) begin
                ref_encode(int'(s_op), int'(s_fn), int'(s_ra), int'(s_rb), int'(s_imm), code, kind);
                if (kind == 3) begin
                    m_state[i] = M_ERR;
                    m_ec[i]    = 3;
                end else if (kind == 1) begin
                    m_state[i] = M_ERR;
                    m_ec[i]    = 1;
                end else begin
                    old       = m_cnt[i];
                    m_wen[i]  = 1;
                    m_addr[i] = (m_base[i] + old) % 1024;
                    m_data[i] = code;
                    m_cnt[i]  = (old + 1) % 1024;
                    if (s_last) begin
                        m_state[i] = M_DONE;
                    end else if (old == depth_of[i] - 1) begin
                        m_state[i] = M_ERR;
                        m_ec[i]    = 2;
                    end
                end
            end
        end else if (s_start) begin
            m_state[i] = M_LOAD;
            m_base[i]  = int'(s_base);
            m_cnt[i]   = 0;
            m_ec[i]    = 0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic          rdy, wen, dn, er;
            logic [AW-1:0] ad, cn;
            logic [8:0]    wd;
            logic [1:0]    ec;
            if (i == 0) begin
                rdy = bus_a.in_ready; wen = bus_a.im_wen; ad = bus_a.im_addr; wd = bus_a.im_wdata;
                cn = count_a; dn = done_a; er = err_a; ec = ec_a;
            end else begin
                rdy = bus_b.in_ready; wen = bus_b.im_wen; ad = bus_b.im_addr; wd = bus_b.im_wdata;
                cn = count_b; dn = done_b; er = err_b; ec = ec_b;
            end
            chk($sformatf("d%0d_in_ready", i), 32'(rdy), 32'(m_state[i] == M_LOAD));
            chk($sformatf("d%0d_im_wen", i),   32'(wen), 32'(m_wen[i]));
            chk($sformatf("d%0d_im_addr", i),  32'(ad),  32'(m_addr[i]));
            chk($sformatf("d%0d_im_wdata", i), 32'(wd),  32'(m_data[i]));
            chk($sformatf("d%0d_count", i),    32'(cn),  32'(m_cnt[i]));
            chk($sformatf("d%0d_done", i),     32'(dn),  32'(m_state[i] == M_DONE));
            chk($sformatf("d%0d_err", i),      32'(er),  32'(m_state[i] == M_ERR));
            chk($sformatf("d%0d_err_code", i), 32'(ec),  32'(m_ec[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_outputs();
    endtask

    task automatic set_word(input logic [3:0] op, input logic [1:0] fn, input logic [2:0] ra,
                            input logic [2:0] rb, input logic [4:0] imm, input logic last);
        s_valid = 1'b1;
        s_op = op; s_fn = fn; s_ra = ra; s_rb = rb; s_imm = imm; s_last = last;
    endtask

    task automatic pulse_start(input logic [AW-1:0] base);
        s_valid = 1'b0;
        s_start = 1'b1;
        s_base  = base;
        tick();
        s_start = 1'b0;
    endtask

    // Called at posedge+1: reset asserts between clock edges, released at the negedge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_wen_a", 32'(bus_a.im_wen), 32'd0);
        chk("rst_ready_a", 32'(bus_a.in_ready), 32'd0);
        #1 rst_n = 1'b1;
    endtask

    logic [8:0] burst_exp [4];

    initial begin
        burst_exp = '{9'h18B, 9'h131, 9'h016, 9'h036};
        model_reset();
        #2 rst_n = 1'b0;
        #2;
        check_outputs();
        #3 rst_n = 1'b1;

        // Single ADDI program.
        pulse_start(10'h010);
        set_word(OP_ADDI, 2'd0, 3'd2, 3'd0, 5'd5, 1'b1);
        tick();
        chk("addi_wen", 32'(bus_a.im_wen), 32'd1);
        chk("addi_addr", 32'(bus_a.im_addr), 32'h010);
        chk("addi_wdata", 32'(bus_a.im_wdata), 32'h1D5);
        s_valid = 1'b0;
        tick();
        chk("addi_done", 32'(done_a), 32'd1);
        chk("addi_count", 32'(count_a), 32'd1);

        // Back-to-back burst.
        pulse_start(10'h020);
        set_word(OP_BEQ, 2'd0, 3'd1, 3'd3, 5'd0, 1'b0);
        tick();
        chk("burst0", 32'(bus_a.im_wdata), 32'(burst_exp[0]));
        set_word(OP_JMP, 2'd0, 3'd0, 3'd0, 5'd17, 1'b0);
        tick();
        chk("burst1", 32'(bus_a.im_wdata), 32'(burst_exp[1]));
        set_word(OP_LDR, 2'd0, 3'd5, 3'd2, 5'd0, 1'b0);
        tick();
        chk("burst2", 32'(bus_a.im_wdata), 32'(burst_exp[2]));
        set_word(OP_STR, 2'd0, 3'd2, 3'd6, 5'd0, 1'b1);
        tick();
        chk("burst3", 32'(bus_a.im_wdata), 32'(burst_exp[3]));
        chk("burst3_addr", 32'(bus_a.im_addr), 32'h023);

        // Unary encoding, then an illegal ALU register.
        pulse_start(10'h040);
        set_word(OP_UNARY, 2'd1, 3'd1, 3'd0, 5'd0, 1'b0);
        tick();
        chk("unary_wdata", 32'(bus_a.im_wdata), 32'h0B9);
        set_word(OP_ALU, 2'd0, 3'd4, 3'd1, 5'd0, 1'b0);
        tick();
        chk("illegal_wen", 32'(bus_a.im_wen), 32'd0);
        chk("illegal_code", 32'(ec_a), 32'd1);
        chk("illegal_count", 32'(count_a), 32'd1);

        // Overflow on the DEPTH=4 build, with the address wrapping past the top.
        pulse_start(10'h3FE);
        for (int k = 0; k < 5; k++) begin
            set_word(OP_MOV, 2'd0, 3'(k), 3'(7 - k), 5'd0, 1'b0);
            tick();
            if (k == 3) begin
                chk("ovf_wen_b", 32'(bus_b.im_wen), 32'd1);
                chk("ovf_addr_b", 32'(bus_b.im_addr), 32'h001);
                chk("ovf_code_b", 32'(ec_b), 32'd2);
                chk("ovf_ready_b", 32'(bus_b.in_ready), 32'd0);
            end
        end
        set_word(OP_BRC, 2'd0, 3'd0, 3'd0, 5'd3, 1'b1);
        tick();

        // Async reset mid-burst, then a clean restart.
        pulse_start(10'h080);
        set_word(OP_BLT, 2'd0, 3'd3, 3'd4, 5'd0, 1'b0);
        tick();
        tick();
        async_reset();
        pulse_start(10'h090);
        set_word(OP_SHL, 2'd0, 3'd6, 3'd0, 5'd7, 1'b1);
        tick();
        chk("restart_count", 32'(count_a), 32'd1);
        chk("restart_addr", 32'(bus_a.im_addr), 32'h090);

        // start while loading is ignored; unknown class; restart from ERR.
        pulse_start(10'h100);
        set_word(OP_SUBI, 2'd0, 3'd3, 3'd0, 5'd2, 1'b0);
        tick();
        s_start = 1'b1;
        s_base  = 10'h200;
        set_word(OP_MOV, 2'd0, 3'd1, 3'd2, 5'd0, 1'b0);
        tick();
        s_start = 1'b0;
        chk("ign_start_addr", 32'(bus_a.im_addr), 32'h101);
        set_word(4'hF, 2'd0, 3'd0, 3'd0, 5'd0, 1'b0);
        tick();
        chk("unknown_code", 32'(ec_a), 32'd3);
        pulse_start(10'h150);
        chk("err_restart_ready", 32'(bus_a.in_ready), 32'd1);
        chk("err_restart_err", 32'(err_a), 32'd0);
        chk("err_restart_count", 32'(count_a), 32'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            s_start = ($urandom_range(0, 9) == 0);
            s_base  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1020, 1023)) : AW'($urandom);
            s_valid = ($urandom_range(0, 3) != 0);
            s_op    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            s_fn    = 2'($urandom);
            s_ra    = 3'($urandom);
            s_rb    = 3'($urandom);
            s_imm   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            s_last  = ($urandom_range(0, 5) == 0);
            tick();
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1);
    end
endmodule
